// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encodings,
// write-back control bit positions and the default datapath width.
package mem_stage_pkg;

   localparam int DW_DEFAULT = 32;

   // Write-back control bit positions inside WB_i / WB_o.
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;

   // Transaction FSM encodings.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'b00;
   localparam state_t BUSY = 2'b01;
   localparam state_t DONE = 2'b10;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Loads when en is high and otherwise holds, so the
// forwarding source stays alive while the front of the pipe is stalled.
module mem_wb_reg
   import mem_stage_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en,
   input  logic [1:0]    wb_d,
   input  logic [4:0]    rd_d,
   input  logic [DW-1:0] alu_d,
   input  logic [DW-1:0] mem_d,
   output logic [1:0]    wb_q,
   output logic [4:0]    rd_q,
   output logic [DW-1:0] alu_q,
   output logic [DW-1:0] mem_q
);

   // Pipeline register with hold enable; cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wb_q  <= '0;
         rd_q  <= '0;
         alu_q <= '0;
         mem_q <= '0;
      end else if (en) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         wb_q  <= wb_d;
         rd_q  <= rd_d;
         alu_q <= alu_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs a req/ack transaction against a multi-cycle data
// memory, stalls the front of the pipe while it is outstanding, and holds the
// MEM/WB register. Optional macro MEM_STAGE_TIMEOUT_EN adds a BUSY-cycle
// watchdog that aborts the access, squashes write-back and sets err_o.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DW      = DW_DEFAULT,
   parameter int TIMEOUT = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [1:0]    WB_i,
   input  logic          MemRead_i,
   input  logic          MemWrite_i,
   input  logic [4:0]    RDaddr_i,
   input  logic [DW-1:0] ALUdata_i,
   input  logic [DW-1:0] data_i,
   output logic          dmem_req_o,
   output logic          dmem_we_o,
   output logic [DW-1:0] dmem_addr_o,
   output logic [DW-1:0] dmem_wdata_o,
   input  logic          dmem_ack_i,
   input  logic [DW-1:0] dmem_rdata_i,
   output logic          stall_o,
   output logic [1:0]    WB_o,
   output logic          FW_o,
   output logic [4:0]    RDaddr_o,
   output logic [DW-1:0] ALUdata_o,
   output logic [DW-1:0] MEMdata_o
`ifdef MEM_STAGE_TIMEOUT_EN
   ,
   output logic          err_o
`endif
);

   state_t        state_q;
   logic [DW-1:0] cap_data;
   logic          aborted;
   logic          access;
   logic          wb_en;
   logic [1:0]    wb_next;
   logic [DW-1:0] mem_next;

   assign access = MemRead_i | MemWrite_i;

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
   logic       timeout_hit;

   assign timeout_hit = (cnt == TO_LAST);

   // BUSY-cycle counter; clears in every other state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                cnt <= '0;
      else if (state_q == BUSY)  cnt <= cnt + 8'd1;
      else                       cnt <= '0;
   end
`else
   assign aborted = 1'b0;
`endif

   // Transaction FSM plus the registered memory request and capture register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         dmem_req_o   <= 1'b0;
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         cap_data     <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
         aborted      <= 1'b0;
         err_o        <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (access) begin
                  state_q      <= BUSY;
                  dmem_req_o   <= 1'b1;
                  // A simultaneous read and write is treated as a store.
                  dmem_we_o    <= MemWrite_i;
                  dmem_addr_o  <= ALUdata_i;
                  dmem_wdata_o <= data_i;
`ifdef MEM_STAGE_TIMEOUT_EN
                  aborted      <= 1'b0;
`endif
               end
            end
            BUSY: begin
               if (dmem_ack_i) begin
                  cap_data   <= dmem_we_o ? '0 : dmem_rdata_i;
                  dmem_req_o <= 1'b0;
                  dmem_we_o  <= 1'b0;
                  state_q    <= DONE;
               end
`ifdef MEM_STAGE_TIMEOUT_EN
               else if (timeout_hit) begin
                  cap_data   <= '0;
                  dmem_req_o <= 1'b0;
                  dmem_we_o  <= 1'b0;
                  aborted    <= 1'b1;
                  err_o      <= 1'b1;
                  state_q    <= DONE;
               end
`endif
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall and MEM/WB load control; stall is forced low while reset is held.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      wb_en    = 1'b0;
      wb_next  = WB_i;
      mem_next = '0;
      stall_o  = 1'b0;
      case (state_q)
         IDLE: begin
            wb_en   = ~access;
            stall_o = access;
         end
         BUSY: stall_o = 1'b1;
         DONE: begin
            wb_en    = 1'b1;
            mem_next = cap_data;
            if (aborted) wb_next = 2'b00;
         end
         default: ;
      endcase
      stall_o = stall_o & rst_i;
   end

   mem_wb_reg #(.DW(DW)) u_mem_wb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (wb_en),
      .wb_d  (wb_next),
      .rd_d  (RDaddr_i),
      .alu_d (ALUdata_i),
      .mem_d (mem_next),
      .wb_q  (WB_o),
      .rd_q  (RDaddr_o),
      .alu_q (ALUdata_o),
      .mem_q (MEMdata_o)
   );

   assign FW_o = WB_o[WB_REGWRITE];

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Timeout vectors run only when
// MEM_STAGE_TIMEOUT_EN is defined (TIMEOUT is set to 4 here).
module tb_mem_stage;

   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [1:0]    WB_i;
   logic          MemRead_i, MemWrite_i;
   logic [4:0]    RDaddr_i;
   logic [DW-1:0] ALUdata_i, data_i;
   logic          dmem_req_o, dmem_we_o;
   logic [DW-1:0] dmem_addr_o, dmem_wdata_o;
   logic          dmem_ack_i;
   logic [DW-1:0] dmem_rdata_i;
   logic          stall_o;
   logic [1:0]    WB_o;
   logic          FW_o;
   logic [4:0]    RDaddr_o;
   logic [DW-1:0] ALUdata_o, MEMdata_o;
`ifdef MEM_STAGE_TIMEOUT_EN
   logic          err_o;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   int stall_cnt;

   always #5 clk_i = ~clk_i;

   mem_stage #(.DW(DW), .TIMEOUT(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .WB_i         (WB_i),
      .MemRead_i    (MemRead_i),
      .MemWrite_i   (MemWrite_i),
      .RDaddr_i     (RDaddr_i),
      .ALUdata_i    (ALUdata_i),
      .data_i       (data_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i),
      .stall_o      (stall_o),
      .WB_o         (WB_o),
      .FW_o         (FW_o),
      .RDaddr_o     (RDaddr_o),
      .ALUdata_o    (ALUdata_o),
      .MEMdata_o    (MEMdata_o)
`ifdef MEM_STAGE_TIMEOUT_EN
      ,
      .err_o        (err_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [1:0] wb, input logic mr, input logic mw,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] dat);
      WB_i = wb; MemRead_i = mr; MemWrite_i = mw;
      RDaddr_i = rd; ALUdata_i = alu; data_i = dat;
   endtask

   initial begin
      rst_i = 1'b0;
      dmem_ack_i = 1'b0;
      dmem_rdata_i = '0;
      drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      repeat (3) next();
      check("rst_req",   32'(dmem_req_o), 32'd0);
      check("rst_stall", 32'(stall_o),    32'd0);
      check("rst_wb",    32'(WB_o),       32'd0);
      check("rst_mem",   MEMdata_o,       32'h0);
      rst_i = 1'b1;

      // ALU op: no memory access, registered one edge later.
      next();
      drive(2'b01, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
      #1;
      check("alu_stall", 32'(stall_o), 32'd0);

      // Load of 0x40, ack in the third BUSY cycle.
      next();
      check("alu_wb",  32'(WB_o),     32'd1);
      check("alu_fw",  32'(FW_o),     32'd1);
      check("alu_rd",  32'(RDaddr_o), 32'd5);
      check("alu_dat", ALUdata_o,     32'h1234);
      drive(2'b11, 1'b1, 1'b0, 5'd7, 32'h40, 32'h0);
      #1;
      check("ld_idle_stall", 32'(stall_o),    32'd1);
      check("ld_idle_req",   32'(dmem_req_o), 32'd0);
      stall_cnt = int'(stall_o);
      for (int i = 0; i < 3; i++) begin
         next();
         if (i == 2) begin
            dmem_ack_i = 1'b1;
            dmem_rdata_i = 32'hCAFEF00D;
         end
         #1;
         stall_cnt += int'(stall_o);
         check("ld_busy_req",  32'(dmem_req_o), 32'd1);
         check("ld_busy_addr", dmem_addr_o,     32'h40);
         check("ld_busy_we",   32'(dmem_we_o),  32'd0);
         check("ld_hold_wb",   32'(WB_o),       32'd1);
      end
      next();
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'h0;
      #1;
      check("ld_done_stall", 32'(stall_o),    32'd0);
      check("ld_done_req",   32'(dmem_req_o), 32'd0);
      check("ld_stall_cnt",  32'(stall_cnt),  32'd4);

      // Back-to-back ALU op; a stray ack in IDLE must be ignored.
      next();
      check("ld_wb",  32'(WB_o),     32'd3);
      check("ld_mem", MEMdata_o,     32'hCAFEF00D);
      check("ld_rd",  32'(RDaddr_o), 32'd7);
      check("ld_alu", ALUdata_o,     32'h40);
      drive(2'b01, 1'b0, 1'b0, 5'd9, 32'h55, 32'h0);
      dmem_ack_i = 1'b1;
      #1;
      check("b2b_stall",   32'(stall_o),    32'd0);
      check("b2b_noreq",   32'(dmem_req_o), 32'd0);

      // Store of 0xA5A5A5A5 to 0x80, ack in the first BUSY cycle.
      next();
      dmem_ack_i = 1'b0;
      check("b2b_rd",  32'(RDaddr_o), 32'd9);
      check("b2b_mem", MEMdata_o,     32'h0);
      check("b2b_wb",  32'(WB_o),     32'd1);
      check("b2b_req", 32'(dmem_req_o), 32'd0);
      drive(2'b00, 1'b0, 1'b1, 5'd3, 32'h80, 32'hA5A5A5A5);
      #1;
      stall_cnt = int'(stall_o);
      next();
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'hDEADBEEF;
      #1;
      stall_cnt += int'(stall_o);
      check("st_req",   32'(dmem_req_o), 32'd1);
      check("st_we",    32'(dmem_we_o),  32'd1);
      check("st_wdata", dmem_wdata_o,    32'hA5A5A5A5);
      check("st_addr",  dmem_addr_o,     32'h80);
      next();
      dmem_ack_i = 1'b0;
      dmem_rdata_i = 32'h0;
      #1;
      check("st_done_stall", 32'(stall_o),   32'd0);
      check("st_stall_cnt",  32'(stall_cnt), 32'd2);

      // Load then reset asserted mid-BUSY.
      next();
      check("st_mem", MEMdata_o,     32'h0);
      check("st_rd",  32'(RDaddr_o), 32'd3);
      check("st_alu", ALUdata_o,     32'h80);
      check("st_wb",  32'(WB_o),     32'd0);
      drive(2'b11, 1'b1, 1'b0, 5'd12, 32'h100, 32'h0);
      next();
      check("rb_busy_req", 32'(dmem_req_o), 32'd1);
      rst_i = 1'b0;
      #1;
      check("rb_req",   32'(dmem_req_o), 32'd0);
      check("rb_stall", 32'(stall_o),    32'd0);
      check("rb_rd",    32'(RDaddr_o),   32'd0);
      check("rb_alu",   ALUdata_o,       32'h0);
      check("rb_addr",  dmem_addr_o,     32'h0);
      drive(2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      dmem_ack_i = 1'b1;
      dmem_rdata_i = 32'h11112222;
      next();
      rst_i = 1'b1;
      next();
      check("late_ack_req",   32'(dmem_req_o), 32'd0);
      check("late_ack_stall", 32'(stall_o),    32'd0);
      dmem_ack_i = 1'b0;
      drive(2'b01, 1'b0, 1'b0, 5'd21, 32'h77, 32'h0);
      next();
      check("post_rst_rd",  32'(RDaddr_o), 32'd21);
      check("post_rst_mem", MEMdata_o,     32'h0);

`ifdef MEM_STAGE_TIMEOUT_EN
      // Load that never receives an ack: watchdog aborts after 4 BUSY cycles.
      check("to_err_clear", 32'(err_o), 32'd0);
      drive(2'b11, 1'b1, 1'b0, 5'd4, 32'h44, 32'h0);
      #1;
      check("to_idle_stall", 32'(stall_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         next();
         check("to_busy_req", 32'(dmem_req_o), 32'd1);
      end
      next();
      check("to_done_req",   32'(dmem_req_o), 32'd0);
      check("to_done_stall", 32'(stall_o),    32'd0);
      check("to_err",        32'(err_o),      32'd1);
      next();
      check("to_wb",  32'(WB_o),    32'd0);
      check("to_mem", MEMdata_o,    32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
